// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered adder/subtractor.
// Op encoding is the raw sel bit, so OP_SUB doubles as the operand-inversion enable.
package full_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic c_out;
    logic over_flow;
  } flags_t;

  // Signed overflow from the two carries that bracket the MSB cell.
  function automatic logic ovf_from_carries(input logic c_msb_in, input logic c_msb_out);
    return c_msb_in ^ c_msb_out;
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One ripple cell: sum and carry of a + b + cin.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_8bit_behavior.sv
// Registered WIDTH-bit adder/subtractor with carry/borrow-in, carry-out and overflow.
// Optional registered zero flag when FULL_ADDER_ZERO_FLAG_EN is defined.
module full_adder_8bit_behavior
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sel,
`ifdef FULL_ADDER_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             over_flow
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] s_comb;
  logic [WIDTH:0]   carry;
  flags_t           flags_comb;
  flags_t           flags_q;

  // Subtract is a + ~b + ~borrow, so both the operand and the carry-in flip on OP_SUB.
  assign bb       = (sel == OP_SUB) ? ~b : b;
  assign carry[0] = c_in ^ sel;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_1bit u_fa (
        .a    (a[i]),
        .b    (bb[i]),
        .cin  (carry[i]),
        .s    (s_comb[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  assign flags_comb.c_out     = carry[WIDTH];
  assign flags_comb.over_flow = ovf_from_carries(carry[WIDTH-1], carry[WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      flags_q <= '0;
    end else begin
      sum     <= s_comb;
      flags_q <= flags_comb;
    end
  end

  assign c_out     = flags_q.c_out;
  assign over_flow = flags_q.over_flow;

`ifdef FULL_ADDER_ZERO_FLAG_EN
  // Registered alongside sum; reset value reflects the cleared sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero <= 1'b1;
    else     zero <= (s_comb == '0);
  end
`endif

endmodule

// File: tb/tb_full_adder_8bit_behavior.sv
// Directed vector bench for full_adder_8bit_behavior, including async reset corners.
module tb_full_adder_8bit_behavior;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       c_in, sel;
  logic [7:0] sum;
  logic       c_out, over_flow;
`ifdef FULL_ADDER_ZERO_FLAG_EN
  logic       zero;
`endif

  int n_run  = 0;
  int n_fail = 0;

  full_adder_8bit_behavior #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sel       (sel),
`ifdef FULL_ADDER_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .sum       (sum),
    .c_out     (c_out),
    .over_flow (over_flow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [7:0] sum;
    logic       co;
    logic       v;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] es, input logic eco, input logic ev);
    chk({name, ".sum"}, sum, es);
    chk({name, ".c_out"}, {7'd0, c_out}, {7'd0, eco});
    chk({name, ".over_flow"}, {7'd0, over_flow}, {7'd0, ev});
`ifdef FULL_ADDER_ZERO_FLAG_EN
    chk({name, ".zero"}, {7'd0, zero}, {7'd0, (es == 8'h00)});
`endif
  endtask

  task automatic drive(input logic s, input logic [7:0] va, input logic [7:0] vb, input logic ci);
    sel  = s;
    a    = va;
    b    = vb;
    c_in = ci;
  endtask

  initial begin
    vecs[0]  = '{"add55_44",  1'b0, 8'h55, 8'h44, 1'b0, 8'h99, 1'b0, 1'b1};
    vecs[1]  = '{"addBB_44",  1'b0, 8'hBB, 8'h44, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{"add11_55",  1'b0, 8'h11, 8'h55, 1'b0, 8'h66, 1'b0, 1'b0};
    vecs[3]  = '{"addFF_55",  1'b0, 8'hFF, 8'h55, 1'b0, 8'h54, 1'b1, 1'b0};
    vecs[4]  = '{"sub55_44",  1'b1, 8'h55, 8'h44, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[5]  = '{"subBB_44",  1'b1, 8'hBB, 8'h44, 1'b0, 8'h77, 1'b1, 1'b1};
    vecs[6]  = '{"sub11_55",  1'b1, 8'h11, 8'h55, 1'b0, 8'hBC, 1'b0, 1'b0};
    vecs[7]  = '{"subFF_55",  1'b1, 8'hFF, 8'h55, 1'b0, 8'hAA, 1'b1, 1'b0};
    vecs[8]  = '{"addFF_00c", 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{"sub00_00b", 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{"add7F_01",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{"sub80_01",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, 8'h12, 8'h34, 1'b0);
    #1;
    chk_out("reset_async", 8'h00, 1'b0, 1'b0);
    // Reset held across an edge must keep outputs cleared.
    @(posedge clk); #1;
    chk_out("reset_hold", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back vectors: one new operation per cycle, one-edge latency.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c_in);
      @(posedge clk); #1;
      chk_out(vecs[i].name, vecs[i].sum, vecs[i].co, vecs[i].v);
      @(negedge clk);
    end

    // Outputs hold between edges while inputs change.
    drive(1'b0, 8'h55, 8'h44, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'h01, 8'h01, 1'b0);
    #3;
    chk_out("hold", 8'h99, 1'b0, 1'b1);

    // Mid-cycle reset pulse clears immediately; the next edge samples fresh inputs.
    @(posedge clk); #1;
    chk_out("pre_rst", 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'hBB, 8'h44, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_out("rst_pulse", 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_out("post_rst", 8'h77, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
